// File: rtl/sram_bram_bridge.sv
// Bridges a CPU load/store port onto a single-port, word-wide BRAM with one-cycle read latency.
// Sub-word stores are performed as a read-modify-write of the containing word.
module sram_bram_bridge #(
    parameter  int RAM_DEPTH = 1024,
    localparam int AW        = $clog2(RAM_DEPTH)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          req,
    input  logic          wr,
    input  logic [1:0]    size,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          addr_ok,
    output logic          data_ok,
    output logic [31:0]   rdata,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_din,
    output logic          ram_we,
    input  logic [31:0]   ram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        RDATA,
        RMW,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q;
    logic [1:0]    lo_q;
    logic [1:0]    size_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          hs;
    logic          we_raw;
    logic [3:0]    lane_mask;
    logic [31:0]   merged;

    assign hs = req & addr_ok;

    // Byte stores touch lane addr[1:0]; halfword stores touch the half chosen by addr[1].
    always_comb begin
        lane_mask = size_q[0] ? (lo_q[1] ? 4'b1100 : 4'b0011) : (4'b0001 << lo_q);
        merged    = ram_dout;
        for (int k = 0; k < 4; k++) begin
            if (lane_mask[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
        end
    end

    // NOTE: every output is given a default before the case so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_ok  = 1'b0;
        data_ok  = 1'b0;
        we_raw   = 1'b0;
        ram_addr = idx_q;
        ram_din  = wdata_q;
        rdata    = rdata_q;
        case (state_q)
            IDLE: begin
                addr_ok  = 1'b1;
                ram_addr = addr[AW+1:2];
                if (req) begin
                    if (!wr) begin
                        state_d = RDATA;
                    end else if (size[1]) begin
                        we_raw  = 1'b1;
                        ram_din = wdata;
                        state_d = DONE;
                    end else begin
                        state_d = RMW;
                    end
                end
            end
            RDATA: begin
                data_ok = 1'b1;
                rdata   = ram_dout;
                state_d = IDLE;
            end
            RMW: begin
                we_raw  = 1'b1;
                ram_din = merged;
                state_d = DONE;
            end
            DONE: begin
                data_ok = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gate with reset so a write already on the bus is dropped in the cycle reset arrives.
    assign ram_we = we_raw & resetn;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                idx_q   <= addr[AW+1:2];
                lo_q    <= addr[1:0];
                size_q  <= size;
                wdata_q <= wdata;
            end
            if (state_q == RDATA) rdata_q <= ram_dout;
        end
    end

endmodule

// File: tb/tb_sram_bram_bridge.sv
// Directed bench for sram_bram_bridge: a stimulus process queues expected responses,
// a monitor pops and compares each data_ok against latency and load data.
module tb_sram_bram_bridge;

    localparam int RAM_DEPTH = 1024;
    localparam int AW        = 10;

    logic          clock = 1'b0;
    logic          resetn;
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [31:0]   rdata;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic          ram_we;
    logic [31:0]   ram_dout;

    typedef struct {
        bit          is_load;
        logic [31:0] data;
        int          hs_cyc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem[RAM_DEPTH];
    int          cyc    = 0;
    int          wcount = 0;
    int          checks = 0;
    int          passed = 0;

    sram_bram_bridge #(.RAM_DEPTH(RAM_DEPTH)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .req      (req),
        .wr       (wr),
        .size     (size),
        .addr     (addr),
        .wdata    (wdata),
        .addr_ok  (addr_ok),
        .data_ok  (data_ok),
        .rdata    (rdata),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    always #5 clock = ~clock;

    // Read-first synchronous BRAM model
    initial for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
    always @(posedge clock) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            wcount        <= wcount + 1;
        end
        ram_dout <= mem[ram_addr];
        cyc      <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (resetn === 1'b1 && data_ok === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_data_ok", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("latency", 32'(cyc - e.hs_cyc), 32'(e.lat));
                if (e.is_load) check("load_rdata", rdata, e.data);
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [AW-1:0] exp_idx,
                         input logic exp_we, input logic [31:0] exp_rd, input int lat,
                         input bit track);
        int   n;
        exp_t e;
        @(negedge clock);
        req = 1'b1; wr = w; size = sz; addr = a; wdata = wd;
        #1;
        n = 0;
        while (!addr_ok && n < 20) begin
            @(negedge clock); #1;
            n++;
        end
        if (!addr_ok) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            check("hs_ram_addr", 32'(ram_addr), 32'(exp_idx));
            check("hs_ram_we", 32'(ram_we), 32'(exp_we));
            if (exp_we) check("hs_ram_din", ram_din, wd);
            if (track) begin
                e.is_load = !w; e.data = exp_rd; e.hs_cyc = cyc; e.lat = lat;
                sb.push_back(e);
            end
        end
        @(posedge clock); #1;
        req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clock); #1;
    endtask

    initial begin
        int wc0;
        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_data_ok", 32'(data_ok), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("rst_addr_ok", 32'(addr_ok), 32'd1);

        // Word store then reload
        issue(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 10'd4, 1'b1, 32'h0, 1, 1'b1);
        issue(1'b0, 2'd2, 32'h10, 32'h0, 10'd4, 1'b0, 32'hDEADBEEF, 1, 1'b1);
        // Byte store into lane 2, then misaligned halfword into upper half
        issue(1'b1, 2'd2, 32'h20, 32'h11223344, 10'd8, 1'b1, 32'h0, 1, 1'b1);
        issue(1'b1, 2'd0, 32'h22, 32'h00AA0000, 10'd8, 1'b0, 32'h0, 2, 1'b1);
        issue(1'b0, 2'd2, 32'h20, 32'h0, 10'd8, 1'b0, 32'h11AA3344, 1, 1'b1);
        issue(1'b1, 2'd1, 32'h23, 32'hBEEF0000, 10'd8, 1'b0, 32'h0, 2, 1'b1);
        issue(1'b0, 2'd2, 32'h20, 32'h0, 10'd8, 1'b0, 32'hBEEF3344, 1, 1'b1);
        drain();

        // req held high across loads: accepts only in IDLE cycles
        @(negedge clock);
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h20; wdata = '0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("held_addr_ok", 32'(addr_ok), 32'(i % 2 == 0));
            check("held_data_ok", 32'(data_ok), 32'(i % 2 == 1));
            check("held_rdata", rdata, 32'hBEEF3344);
            if (addr_ok) sb.push_back('{1'b1, 32'hBEEF3344, cyc, 1});
            @(negedge clock);
        end
        req = 1'b0;
        drain();

        // Address wrap, size=3 as word, byte lane 1
        issue(1'b1, 2'd2, 32'h1000, 32'hCAFEF00D, 10'd0, 1'b1, 32'h0, 1, 1'b1);
        issue(1'b0, 2'd2, 32'h0, 32'h0, 10'd0, 1'b0, 32'hCAFEF00D, 1, 1'b1);
        issue(1'b1, 2'd3, 32'h30, 32'h01234567, 10'd12, 1'b1, 32'h0, 1, 1'b1);
        issue(1'b1, 2'd0, 32'h31, 32'h0000AB00, 10'd12, 1'b0, 32'h0, 2, 1'b1);
        issue(1'b0, 2'd2, 32'h30, 32'h0, 10'd12, 1'b0, 32'h0123AB67, 1, 1'b1);
        drain();

        // Reset during the RMW write cycle of a byte store
        issue(1'b1, 2'd0, 32'h20, 32'h00000077, 10'd8, 1'b0, 32'h0, 0, 1'b0);
        check("rmw_ram_we", 32'(ram_we), 32'd1);
        check("rmw_ram_addr", 32'(ram_addr), 32'd8);
        check("rmw_ram_din", ram_din, 32'hBEEF3377);
        wc0 = wcount;
        resetn = 1'b0;
        #1;
        check("abort_ram_we", 32'(ram_we), 32'd0);
        check("abort_data_ok", 32'(data_ok), 32'd0);
        check("abort_rdata", rdata, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check("abort_addr_ok", 32'(addr_ok), 32'd1);
        check("abort_no_write", 32'(wcount), 32'(wc0));
        issue(1'b0, 2'd2, 32'h20, 32'h0, 10'd8, 1'b0, 32'hBEEF3344, 1, 1'b1);
        drain();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sram_bram_bridge.md
SRAM_BRAM_BRIDGE -- requirements
Module: sram_bram_bridge

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 1024, meaning number of 32-bit words in the attached BRAM; AW = $clog2(RAM_DEPTH).
REQ-002 SHALL have port clock  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  1  CPU request valid.
REQ-005 SHALL have port wr  input  1  1 = store, 0 = load.
REQ-006 SHALL have port size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port wdata  input  32  store data, lane-aligned by the CPU.
REQ-009 SHALL have port addr_ok  output  1  request accepted this cycle when req=1.
REQ-010 SHALL have port data_ok  output  1  one-cycle pulse; transaction complete.
REQ-011 SHALL have port rdata  output  32  load result, full aligned word.
REQ-012 SHALL have port ram_addr  output  AW  BRAM word address.
REQ-013 SHALL have port ram_din  output  32  BRAM write data.
REQ-014 SHALL have port ram_we  output  1  BRAM write enable, whole word only.
REQ-015 SHALL have port ram_dout  input  32  BRAM read data; valid the cycle after ram_addr is presented.

Function
REQ-016 SHALL implement FSM states IDLE, RDATA, RMW, DONE; one transaction outstanding at most.
REQ-017 SHALL assert addr_ok combinationally only in IDLE; handshake = req & addr_ok.
REQ-018 SHALL in IDLE drive ram_addr = addr[AW+1:2] combinationally; address bits above AW+1 ignored (wrap modulo RAM_DEPTH).
REQ-019 SHALL ignore misaligned low bits: halfword uses addr[1] only, word uses neither addr[1:0].
REQ-020 SHALL latch addr word index, addr[1:0], size, wdata on handshake.
REQ-021 Load: IDLE -> RDATA; in RDATA capture ram_dout into rdata, pulse data_ok, -> IDLE; data_ok 1 cycle after handshake.
REQ-022 Word store: in handshake cycle drive ram_we=1, ram_din=wdata; -> DONE; DONE pulses data_ok, -> IDLE; data_ok 1 cycle after handshake.
REQ-023 Sub-word store: handshake cycle issues read (ram_we=0); -> RMW; RMW drives ram_addr=latched index, ram_we=1, ram_din=ram_dout with selected lane(s) replaced from latched wdata; -> DONE; data_ok 2 cycles after handshake.
REQ-024 SHALL select byte lane addr[1:0] (bits 8*k+7:8*k), halfword lane addr[1] (bits 16*h+15:16*h); other lanes preserved exactly.
REQ-025 SHALL drive ram_we=0 in all states/conditions not listed in REQ-022/REQ-023.
REQ-026 SHALL hold rdata at its last captured value except in RDATA; stores do not alter rdata.
REQ-027 SHALL drive data_ok=1 only in RDATA and DONE, for exactly one cycle per accepted request.
REQ-028 Back-to-back: a new request MAY be accepted in the cycle after data_ok (IDLE); a load following a store to the same word SHALL return the stored value.
REQ-029 req while not in IDLE SHALL be ignored (not latched) until addr_ok.

Reset
REQ-030 On resetn=0, asynchronously: state=IDLE, rdata=0, latched fields=0, data_ok=0, ram_we=0.
REQ-031 Reset mid-transaction SHALL abort it: no data_ok, no later BRAM write; a write in the reset cycle itself is suppressed.
REQ-032 After resetn deasserts, addr_ok=1 in first cycle; BRAM contents not cleared by this block.

Verification
REQ-033 Word store addr=0x10 wdata=0xDEADBEEF, then load 0x10 -> ram_we 1 cycle at ram_addr=4; data_ok next cycle; load data_ok 1 cycle after handshake, rdata=0xDEADBEEF.
REQ-034 Word 0x11223344 at 0x20, byte store addr=0x22 wdata=0x00AA0000 -> read then write cycle, data_ok 2 cycles after handshake; reload = 0x11AA3344.
REQ-035 Halfword store addr=0x23 (misaligned) wdata=0xBEEF0000 onto 0x11AA3344 -> word becomes 0xBEEF3344.
REQ-036 req held high across a load -> addr_ok only in IDLE cycles; exactly one data_ok per accept; rdata unchanged between.
REQ-037 resetn low during RMW of byte store -> no ram_we pulse, no data_ok; word unchanged on reload; rdata=0 after reset.
REQ-038 addr=0x1000 with RAM_DEPTH=1024 -> ram_addr=0 (wrap).
